// File: rtl/ysyx_23060124_ifu_pkg.sv
// ysyx_23060124_ifu_pkg
// Shared definitions for the instruction fetch unit: bus width, the
// instruction substituted on a fetch error, the OKAY read response code
// and the 3-bit fetch FSM state encoding.
package ysyx_23060124_ifu_pkg;

    localparam int ISA_WIDTH = 32;

    // Harmless ADDI x0,x0,0 handed to decode whenever the fetch failed
    localparam logic [ISA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_AR   = 3'd1,
        IFU_R    = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_DROP = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060124_ifu.sv
// ysyx_23060124_ifu
// Instruction fetch unit. Takes one PC per handshake from the PC unit,
// issues a single-beat read on the instruction memory read channel and
// hands the fetched word plus its PC to decode over valid/ready.
// Ports:
//   clk, i_rst_n                    clock, async active-low reset
//   i_pc, i_pc_valid, o_pc_ready    PC input handshake
//   o_araddr, o_arvalid, i_arready  read address channel
//   i_rdata, i_rresp, i_rvalid,
//   o_rready                        read data channel
//   o_inst, o_inst_pc, o_fetch_err,
//   o_inst_valid, i_inst_ready      instruction output handshake
//   i_flush                         redirect, discards any fetch in flight
// Every output is a register, so no input reaches an output combinationally.
module ysyx_23060124_ifu
    import ysyx_23060124_ifu_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic [ISA_WIDTH-1:0] i_pc,
    input  logic                 i_pc_valid,
    output logic                 o_pc_ready,
    output logic [ISA_WIDTH-1:0] o_araddr,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [ISA_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [ISA_WIDTH-1:0] o_inst,
    output logic [ISA_WIDTH-1:0] o_inst_pc,
    output logic                 o_fetch_err,
    output logic                 o_inst_valid,
    input  logic                 i_inst_ready,
    input  logic                 i_flush
);

    ifu_state_e           state_q;
    ifu_state_e           state_d;
    logic [ISA_WIDTH-1:0] pc_q;
    logic [ISA_WIDTH-1:0] inst_q;
    logic                 err_q;
    logic                 flush_pend;
    logic                 pc_ready_q;
    logic                 arvalid_q;
    logic                 rready_q;
    logic                 inst_valid_q;
    logic                 misaligned;

    assign misaligned = (i_pc[1:0] != 2'b00);

    // Next-state selection. A flush seen while the address is still being
    // offered cannot retract arvalid, so it is remembered in flush_pend and
    // steers the address handshake into DROP. In HOLD a flush wins over a
    // simultaneous i_inst_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: begin
                if (i_pc_valid) begin
                    state_d = misaligned ? IFU_HOLD : IFU_AR;
                end
            end
            IFU_AR: begin
                if (i_arready) begin
                    state_d = (flush_pend || i_flush) ? IFU_DROP : IFU_R;
                end
            end
            IFU_R: begin
                if (i_flush) begin
                    state_d = i_rvalid ? IFU_IDLE : IFU_DROP;
                end else if (i_rvalid) begin
                    state_d = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (i_flush || i_inst_ready) begin
                    state_d = IFU_IDLE;
                end
            end
            IFU_DROP: begin
                if (i_rvalid) begin
                    state_d = IFU_IDLE;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    // State, data and output registers. Handshake outputs are decoded from
    // the next state so they line up with the state they belong to. A
    // misaligned PC never reaches the bus; it is reported with a NOP.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IFU_IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            err_q        <= 1'b0;
            flush_pend   <= 1'b0;
            pc_ready_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_ready_q   <= (state_d == IFU_IDLE);
            arvalid_q    <= (state_d == IFU_AR);
            rready_q     <= (state_d == IFU_R) || (state_d == IFU_DROP);
            inst_valid_q <= (state_d == IFU_HOLD);

            if (state_q == IFU_IDLE && i_pc_valid) begin
                pc_q  <= i_pc;
                err_q <= misaligned;
                if (misaligned) begin
                    inst_q <= NOP_INST;
                end
            end

            if (state_q == IFU_R && i_rvalid && !i_flush) begin
                err_q  <= (i_rresp != RESP_OKAY);
                inst_q <= (i_rresp != RESP_OKAY) ? NOP_INST : i_rdata;
            end

            if (state_q == IFU_AR && !i_arready) begin
                flush_pend <= flush_pend | i_flush;
            end else begin
                flush_pend <= 1'b0;
            end
        end
    end

    assign o_pc_ready   = pc_ready_q;
    assign o_araddr     = pc_q;
    assign o_arvalid    = arvalid_q;
    assign o_rready     = rready_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = pc_q;
    assign o_fetch_err  = err_q;
    assign o_inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// tb_ysyx_23060124_ifu
// Self-checking bench for the instruction fetch unit. A table of fetch
// vectors (PC, memory response, wait counts, expected word/error) is played
// cycle by cycle; expected results are queued when a PC is offered and
// popped when decode takes the instruction. Flush-in-AR and async reset in
// R are covered by hand-written sequences.
module tb_ysyx_23060124_ifu;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic        o_pc_ready;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_fetch_err;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic        i_flush;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait;
        int          r_wait;
        int          ir_wait;
        bit          flush_hold;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;
    int   ar_hs  = 0;
    int   r_hs   = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    // Count bus handshakes so each fetch can be checked for exactly one
    // address and one data transfer
    always @(posedge clk) begin
        if (o_arvalid && i_arready) ar_hs++;
        if (o_rready && i_rvalid) r_hs++;
    end

    ysyx_23060124_ifu dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_pc         (i_pc),
        .i_pc_valid   (i_pc_valid),
        .o_pc_ready   (o_pc_ready),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_fetch_err  (o_fetch_err),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .i_flush      (i_flush)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plays one fetch vector from PC offer to decode handshake, checking
    // exact cycle positions of every handshake along the way
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   ar0;
        int   r0;
        logic mis;
        mis    = (v.pc[1:0] != 2'b00);
        e.inst = v.exp_inst;
        e.pc   = v.pc;
        e.err  = v.exp_err;
        if (!v.flush_hold) sb.push_back(e);
        ar0 = ar_hs;
        r0  = r_hs;
        checkOutput("pc_ready", o_pc_ready, 1);
        i_pc = v.pc;
        i_pc_valid = 1'b1;
        step();
        i_pc_valid = 1'b0;
        i_pc = '0;
        if (!mis) begin
            checkOutput("arvalid", o_arvalid, 1);
            for (int k = 0; k < v.ar_wait; k++) begin
                checkOutput("araddr_hold", o_araddr, v.pc);
                step();
                checkOutput("arvalid_hold", o_arvalid, 1);
            end
            checkOutput("araddr", o_araddr, v.pc);
            i_arready = 1'b1;
            step();
            i_arready = 1'b0;
            checkOutput("rready", o_rready, 1);
            for (int k = 0; k < v.r_wait; k++) begin
                step();
                checkOutput("rready_hold", o_rready, 1);
            end
            i_rvalid = 1'b1;
            i_rdata  = v.rdata;
            i_rresp  = v.rresp;
            step();
            i_rvalid = 1'b0;
            i_rdata  = '0;
            i_rresp  = 2'b00;
        end else begin
            checkOutput("arvalid_misalign", o_arvalid, 0);
        end
        checkOutput("inst_valid", o_inst_valid, 1);
        if (v.flush_hold) begin
            i_flush = 1'b1;
            i_inst_ready = 1'b1;
            step();
            i_flush = 1'b0;
            i_inst_ready = 1'b0;
            checkOutput("flush_hold_drop", o_inst_valid, 0);
            checkOutput("flush_hold_idle", o_pc_ready, 1);
        end else begin
            for (int k = 0; k < v.ir_wait; k++) begin
                checkOutput("inst_hold", o_inst, v.exp_inst);
                checkOutput("inst_pc_hold", o_inst_pc, v.pc);
                step();
                checkOutput("inst_valid_hold", o_inst_valid, 1);
            end
            i_inst_ready = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got empty queue expected entry for %h", v.pc);
            end else begin
                e = sb.pop_front();
                checkOutput("inst", o_inst, e.inst);
                checkOutput("inst_pc", o_inst_pc, e.pc);
                checkOutput("fetch_err", {31'b0, o_fetch_err}, {31'b0, e.err});
            end
            step();
            i_inst_ready = 1'b0;
            checkOutput("valid_drop", o_inst_valid, 0);
        end
        checkOutput("ar_count", ar_hs - ar0, mis ? 0 : 1);
        checkOutput("r_count", r_hs - r0, mis ? 0 : 1);
    endtask

    // Main sequence: reset, vector table, flush in AR, async reset in R
    initial begin
        int ar0;
        int r0;
        vec_t nv;
        vecs[0] = '{32'h8000_0000, 32'h0010_0093, 2'b00, 0, 0, 0, 1'b0, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h0020_0113, 2'b00, 3, 2, 4, 1'b0, 32'h0020_0113, 1'b0};
        vecs[2] = '{32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, 1'b0, 32'h0000_0013, 1'b1};
        vecs[3] = '{32'h8000_0002, 32'h0000_0000, 2'b00, 0, 0, 2, 1'b0, 32'h0000_0013, 1'b1};
        vecs[4] = '{32'h8000_000C, 32'h0030_0193, 2'b11, 1, 0, 1, 1'b0, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h8000_0010, 32'h0040_0213, 2'b00, 0, 0, 0, 1'b1, 32'h0040_0213, 1'b0};
        vecs[6] = '{32'h8000_0014, 32'h0050_0293, 2'b00, 0, 0, 0, 1'b0, 32'h0050_0293, 1'b0};

        i_rst_n = 1'b0;
        i_pc = '0;
        i_pc_valid = 1'b0;
        i_arready = 1'b0;
        i_rdata = '0;
        i_rresp = 2'b00;
        i_rvalid = 1'b0;
        i_inst_ready = 1'b0;
        i_flush = 1'b0;
        #3;
        checkOutput("rst_ctrl", {28'b0, o_pc_ready, o_arvalid, o_rready, o_inst_valid}, 0);
        checkOutput("rst_inst", o_inst, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        step();
        checkOutput("rst_idle", o_pc_ready, 1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Flush while the address is waiting: the old read completes into
        // DROP and the redirect target is fetched next
        $display("[TB] flush in AR");
        ar0 = ar_hs;
        r0  = r_hs;
        i_pc = 32'h8000_0040;
        i_pc_valid = 1'b1;
        step();
        i_pc_valid = 1'b0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        checkOutput("flush_ar_arvalid", o_arvalid, 1);
        checkOutput("flush_ar_araddr", o_araddr, 32'h8000_0040);
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        checkOutput("drop_rready", o_rready, 1);
        checkOutput("drop_no_valid", o_inst_valid, 0);
        i_rvalid = 1'b1;
        i_rdata = 32'h1234_5678;
        step();
        i_rvalid = 1'b0;
        i_rdata = '0;
        checkOutput("drop_no_valid2", o_inst_valid, 0);
        checkOutput("drop_hs", (ar_hs - ar0) * 16 + (r_hs - r0), 32'h11);
        nv = '{32'h8000_0100, 32'h0060_0313, 2'b00, 0, 0, 0, 1'b0, 32'h0060_0313, 1'b0};
        applyStimulus(nv);

        // Asynchronous reset between edges while waiting for read data
        $display("[TB] async reset in R");
        i_pc = 32'h8000_0200;
        i_pc_valid = 1'b1;
        step();
        i_pc_valid = 1'b0;
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        checkOutput("pre_rst_rready", o_rready, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ctrl", {28'b0, o_pc_ready, o_arvalid, o_rready, o_inst_valid}, 0);
        checkOutput("async_rst_araddr", o_araddr, 0);
        checkOutput("async_rst_inst", o_inst, 0);
        checkOutput("async_rst_inst_pc", o_inst_pc, 0);
        checkOutput("async_rst_err", {31'b0, o_fetch_err}, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        step();
        checkOutput("post_rst_idle", o_pc_ready, 1);
        checkOutput("post_rst_rready", o_rready, 0);
        applyStimulus(vecs[6]);

        checkOutput("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_ifu.md
# ysyx_23060124_ifu

Instruction fetch unit: consumer of the program counter produced by the PC unit. It accepts one PC per handshake, issues a single-beat read on the instruction memory read channel, and presents the fetched instruction with its PC to decode over a valid/ready handshake. It sits between the PC unit and the IDU, and is the only block in the core that drives the instruction read channel.

## Interface
- `ISA_WIDTH`, 32: address and data width.
- `NOP_INST`, 32'h0000_0013: instruction word presented on a fetch error.

- `clk`  in  1  core clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_pc`  in  ISA_WIDTH  fetch address from the PC unit.
- `i_pc_valid`  in  1  `i_pc` is valid.
- `o_pc_ready`  out  1  IFU accepts `i_pc` this cycle.
- `o_araddr`  out  ISA_WIDTH  read address.
- `o_arvalid`  out  1  read address valid.
- `i_arready`  in  1  memory accepts the address.
- `i_rdata`  in  ISA_WIDTH  read data.
- `i_rresp`  in  2  read response; 2'b00 is OKAY, anything else is an error.
- `i_rvalid`  in  1  read data valid.
- `o_rready`  out  1  IFU accepts read data.
- `o_inst`  out  ISA_WIDTH  fetched instruction.
- `o_inst_pc`  out  ISA_WIDTH  PC of `o_inst`.
- `o_fetch_err`  out  1  bus error or misaligned PC, qualified by `o_inst_valid`.
- `o_inst_valid`  out  1  instruction valid to the IDU.
- `i_inst_ready`  in  1  IDU accepts the instruction.
- `i_flush`  in  1  redirect: discard any fetch in flight.

## Operation
- FSM states: IDLE, AR, R, HOLD, DROP. Reset state is IDLE.
- IDLE:
  - `o_pc_ready`=1.
  - On `i_pc_valid`, latch `i_pc` into `pc_q`.
  - If `i_pc[1:0]`!=0, go to HOLD with the error flag set and no bus request.
  - Otherwise go to AR.
- AR:
  - `o_arvalid`=1 and `o_araddr`=`pc_q`. Both are held stable until `i_arready`.
  - On `i_arready`, go to R. If a flush is pending, go to DROP instead.
- R:
  - `o_rready`=1.
  - On `i_rvalid`, latch `i_rdata` into `inst_q`. Set `err_q` when `i_rresp`!=0, in which case `inst_q`=`NOP_INST`. Go to HOLD.
- HOLD:
  - `o_inst_valid`=1, `o_inst`=`inst_q`, `o_inst_pc`=`pc_q`, `o_fetch_err`=`err_q`.
  - On `i_inst_ready`, go to IDLE.
- DROP:
  - `o_rready`=1.
  - On `i_rvalid`, discard the data and go to IDLE.
- Flush handling, by state:
  - IDLE: no effect. A PC offered in the same cycle is accepted, since it is the redirect target.
  - AR: `o_arvalid` may not be withdrawn, so set `flush_pend`. The `i_arready` transition then goes to DROP.
  - R: go to DROP. If `i_rvalid` arrives in the same cycle, discard the data and go to IDLE.
  - HOLD: drop `o_inst_valid` and go to IDLE. Flush takes priority over a simultaneous `i_inst_ready`; the IDU must ignore that beat.
  - DROP: no additional effect.
- At most one read is outstanding; no address pipelining.

## Timing
- Reset values: all outputs are 0; `pc_q`, `inst_q`, `err_q` and `flush_pend` are 0.
- Reset is honoured mid-transaction. The memory side must itself be reset with the same reset.
- All outputs are registered state decodes. There is no combinational path from any input to any output.
- Minimum latency, zero-wait memory:
  - Cycle 0: PC accepted.
  - Cycle 1: `o_arvalid` (with `i_arready`).
  - Cycle 2: `i_rvalid` sampled.
  - Cycle 3: `o_inst_valid`.
- Misaligned PC: `o_inst_valid` with `o_fetch_err` in cycle 1.
- Throughput is at most one instruction per 4 cycles (single-cycle core, no prefetch).
- Valid/ready rule: once asserted, `o_arvalid` and `o_inst_valid` stay high with stable payload until their handshake completes. The only exception is the flush-in-HOLD case.

## Structure
- Shared package `ysyx_23060124_ifu_pkg`:
  - FSM state encoding, 3-bit.
  - `RESP_OKAY`=2'b00.
  - `NOP_INST`.
- The package also goes in `para_defines.v` alongside `ISA_WIDTH`.
- No sub-module. State and data registers are inline, with async active-low reset.

## Test plan
- Zero-wait fetch: PC=32'h8000_0000, rdata=32'h0010_0093 → `o_inst_valid` in cycle 3, `o_inst`=32'h0010_0093, `o_inst_pc`=32'h8000_0000, err=0.
- Backpressure:
  - `i_arready` held low for 3 cycles, then `i_rvalid` delayed 2 cycles, then `i_inst_ready` low for 4 cycles.
  - → `o_araddr` stable throughout AR.
  - → `o_inst` stable while held.
  - → exactly one AR and one R handshake.
- Bus error: `i_rresp`=2'b10 → `o_fetch_err`=1, `o_inst`=32'h0000_0013.
- Misaligned PC: PC=32'h8000_0002 → no `o_arvalid` ever; `o_inst_valid` with err=1 one cycle after acceptance.
- Flush in AR, then new PC=32'h8000_0100:
  - → the old response is consumed and discarded.
  - → the next delivered instruction has `o_inst_pc`=32'h8000_0100.
- Async reset in R: assert `i_rst_n`=0 between clock edges → all outputs 0 immediately; IDLE with `o_pc_ready`=1 after release.
